// File: rtl/lcd_pkg.sv
// Shared constants and types for the HD44780 character-LCD read/write sequencers.
package lcd_pkg;

    localparam int unsigned CNT_W = 32;

    // Default cycle budgets at 50 MHz.
    localparam int unsigned SETUP_WAIT_DEF   = 2;
    localparam int unsigned E_HIGH_WAIT_DEF  = 12;
    localparam int unsigned HOLD_WAIT_DEF    = 1;
    localparam int unsigned RECOVER_WAIT_DEF = 13;
    localparam int unsigned POLL_LIMIT_DEF   = 100000;

    // Status byte layout: busy flag on top, address counter below.
    localparam int unsigned BF_BIT  = 7;
    localparam logic [6:0]  AC_MASK = 7'h7f;

    localparam logic RS_STATUS = 1'b0;
    localparam logic RS_DATA   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_E_HIGH,
        ST_HOLD,
        ST_RECOVER
    } rd_state_e;

    typedef struct packed {
        logic e;
        logic rs;
        logic rw;
        logic bus_release;
    } lcd_ctl_t;

    function automatic logic status_busy(input logic [7:0] status);
        return status[BF_BIT];
    endfunction

endpackage

// File: rtl/lcd_status_reader_if.sv
// Read-request handshake plus LCD pin group of the status/data reader.
interface lcd_status_reader_if;

    logic       RD_REQ;
    logic       RD_RS;
    logic       RD_POLL;
    logic       RD_READY;
    logic       RD_VALID;
    logic [7:0] RD_DATA;
    logic       RD_TIMEOUT;
    logic [7:0] LCD_DB;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_BUS_RELEASE;

    // Requester side (also owns the input half of the LCD data bus).
    modport master (
        output RD_REQ, RD_RS, RD_POLL, LCD_DB,
        input  RD_READY, RD_VALID, RD_DATA, RD_TIMEOUT,
        input  LCD_E, LCD_RS, LCD_RW, LCD_BUS_RELEASE
    );

    // Reader side.
    modport slave (
        input  RD_REQ, RD_RS, RD_POLL, LCD_DB,
        output RD_READY, RD_VALID, RD_DATA, RD_TIMEOUT,
        output LCD_E, LCD_RS, LCD_RW, LCD_BUS_RELEASE
    );

endinterface

// File: rtl/lcd_wait_timer.sv
// Down-counter: load a cycle count on state entry, flags the final cycle of that count.
module lcd_wait_timer
    import lcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             expire_c
);

    logic [CNT_W-1:0] count;

    // Reload on entry, then count down to zero and stay there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expire_c = (count == CNT_W'(1));

endmodule

// File: rtl/lcd_status_reader.sv
// HD44780 read-cycle sequencer: status or data read, with optional busy-flag polling.
module lcd_status_reader
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_WAIT   = SETUP_WAIT_DEF,
    parameter int unsigned E_HIGH_WAIT  = E_HIGH_WAIT_DEF,
    parameter int unsigned HOLD_WAIT    = HOLD_WAIT_DEF,
    parameter int unsigned RECOVER_WAIT = RECOVER_WAIT_DEF,
    parameter int unsigned POLL_LIMIT   = POLL_LIMIT_DEF
) (
    input  logic                CLK_50MHZ,
    input  logic                BTN_SOUTH,
    lcd_status_reader_if.slave  bus,
    output logic [7:0]          LED
);

    rd_state_e        state, next_state;
    lcd_ctl_t         ctl_d, ctl_q;
    logic             load_c, expire_c;
    logic [CNT_W-1:0] load_value_c;
    logic             rs_c, busy_c, capture_c, retry_c, done_c, timeout_c;
    logic [7:0]       result_c;
    logic             rs_q, poll_q, retry_q;
    logic [CNT_W-1:0] attempts;
    logic             valid_q, timeout_q;
    logic [7:0]       data_q, led_q;

    lcd_wait_timer u_timer (
        .clk      (CLK_50MHZ),
        .rst      (BTN_SOUTH),
        .load     (load_c),
        .value    (load_value_c),
        .expire_c (expire_c)
    );

    // State register.
    always_ff @(posedge CLK_50MHZ or posedge BTN_SOUTH) begin
        if (BTN_SOUTH) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: each phase lasts until its timer expires; RECOVER loops back while polling.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (bus.RD_REQ) next_state = ST_SETUP;
            ST_SETUP:   if (expire_c)   next_state = ST_E_HIGH;
            ST_E_HIGH:  if (expire_c)   next_state = ST_HOLD;
            ST_HOLD:    if (expire_c)   next_state = ST_RECOVER;
            ST_RECOVER: if (expire_c)   next_state = retry_q ? ST_SETUP : ST_IDLE;
            default:                    next_state = ST_IDLE;
        endcase
    end

    // Output decode: pin levels follow the phase being entered so they line up with the state.
    always_comb begin
        ctl_d        = '0;
        load_value_c = '0;
        rs_c         = (state == ST_IDLE) ? bus.RD_RS : rs_q;
        busy_c       = status_busy(bus.LCD_DB);
        capture_c    = (state == ST_E_HIGH) && expire_c;
        retry_c      = poll_q && busy_c && (attempts < CNT_W'(POLL_LIMIT));
        done_c       = capture_c && !retry_c;
        timeout_c    = done_c && poll_q && busy_c;
        result_c     = (rs_q == RS_DATA) ? bus.LCD_DB
                                         : {bus.LCD_DB[BF_BIT], bus.LCD_DB[6:0] & AC_MASK};
        load_c       = (next_state != state);
        case (next_state)
            ST_SETUP: begin
                ctl_d        = '{e: 1'b0, rs: rs_c, rw: 1'b1, bus_release: 1'b1};
                load_value_c = CNT_W'(SETUP_WAIT);
            end
            ST_E_HIGH: begin
                ctl_d        = '{e: 1'b1, rs: rs_c, rw: 1'b1, bus_release: 1'b1};
                load_value_c = CNT_W'(E_HIGH_WAIT);
            end
            ST_HOLD: begin
                ctl_d        = '{e: 1'b0, rs: rs_c, rw: 1'b1, bus_release: 1'b1};
                load_value_c = CNT_W'(HOLD_WAIT);
            end
            ST_RECOVER: begin
                ctl_d        = '{e: 1'b0, rs: rs_c, rw: 1'b0, bus_release: 1'b0};
                load_value_c = CNT_W'(RECOVER_WAIT);
            end
            default: begin
                ctl_d        = '0;
                load_value_c = '0;
            end
        endcase
    end

    // Request context: latch mode on accept, count read attempts, remember poll decision.
    always_ff @(posedge CLK_50MHZ or posedge BTN_SOUTH) begin
        if (BTN_SOUTH) begin
            rs_q     <= 1'b0;
            poll_q   <= 1'b0;
            retry_q  <= 1'b0;
            attempts <= '0;
        end else begin
            if (state == ST_IDLE && next_state == ST_SETUP) begin
                rs_q     <= bus.RD_RS;
                poll_q   <= bus.RD_POLL && (bus.RD_RS == RS_STATUS);
                attempts <= CNT_W'(1);
            end else if (state == ST_RECOVER && next_state == ST_SETUP) begin
                attempts <= attempts + CNT_W'(1);
            end
            if (capture_c) begin
                retry_q <= retry_c;
            end
        end
    end

    // Registered pins and result.
    always_ff @(posedge CLK_50MHZ or posedge BTN_SOUTH) begin
        if (BTN_SOUTH) begin
            ctl_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            data_q    <= 8'h00;
            led_q     <= 8'hff;
        end else begin
            ctl_q     <= ctl_d;
            valid_q   <= done_c;
            timeout_q <= timeout_c;
            if (done_c) begin
                data_q <= result_c;
            end
            led_q     <= done_c ? result_c : data_q;
        end
    end

    assign bus.RD_READY        = (state == ST_IDLE);
    assign bus.RD_VALID        = valid_q;
    assign bus.RD_TIMEOUT      = timeout_q;
    assign bus.RD_DATA         = data_q;
    assign bus.LCD_E           = ctl_q.e;
    assign bus.LCD_RS          = ctl_q.rs;
    assign bus.LCD_RW          = ctl_q.rw;
    assign bus.LCD_BUS_RELEASE = ctl_q.bus_release;
    assign LED                 = led_q;

endmodule

// File: tb/tb_lcd_status_reader.sv
// Bench for lcd_status_reader: panel model, cycle-level reference model and directed reads.
module tb_lcd_status_reader;

    localparam int unsigned LIMIT  = 4;
    // One read attempt spans setup 2 + E high 12 + hold 1 + recover 13 clocks.
    localparam int          PERIOD = 28;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] led;

    lcd_status_reader_if bus();

    lcd_status_reader #(.POLL_LIMIT(LIMIT)) dut (
        .CLK_50MHZ (clk),
        .BTN_SOUTH (rst),
        .bus       (bus),
        .LED       (led)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Responses the panel returns, one per E pulse, for the current request.
    logic [7:0] stim_resp[$];
    int         resp_base = 0;
    int         e_rises   = 0;

    // Panel model: presents the next response while E is high, junk otherwise.
    always @(bus.LCD_E) begin
        if (bus.LCD_E === 1'b1) begin
            if (e_rises - resp_base < stim_resp.size())
                bus.LCD_DB = stim_resp[e_rises - resp_base];
            else
                bus.LCD_DB = 8'hee;
            e_rises++;
        end else begin
            bus.LCD_DB = 8'hee;
        end
    end

    // Reference model: transaction level, timeline derived from the per-attempt phase offsets.
    bit         m_active = 1'b0;
    int         m_t      = 0;
    int         m_n      = 1;
    bit         m_rs     = 1'b0;
    bit         m_poll   = 1'b0;
    bit         m_to     = 1'b0;
    logic [7:0] m_resp[$];
    logic [7:0] m_data   = 8'h00;
    logic [7:0] m_led    = 8'hff;

    function automatic int reads_needed();
        if (!m_poll) return 1;
        for (int i = 0; i < m_resp.size(); i++) begin
            if (!m_resp[i][7] || (i + 1) == int'(LIMIT)) return i + 1;
        end
        return m_resp.size();
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
            m_t      = 0;
            m_data   = 8'h00;
            m_led    = 8'hff;
        end else begin
            if (m_active) begin
                if (m_t == PERIOD * m_n) m_active = 1'b0;
                else m_t++;
            end else if (bus.RD_REQ) begin
                m_active = 1'b1;
                m_t      = 1;
                m_rs     = bus.RD_RS;
                m_poll   = bus.RD_POLL && !bus.RD_RS;
                m_resp   = stim_resp;
                if (m_resp.size() == 0) m_resp.push_back(8'hee);
                m_n      = reads_needed();
                m_to     = m_poll && m_resp[m_n-1][7];
            end
            if (m_active && m_t == PERIOD * (m_n - 1) + 15) m_data = m_resp[m_n-1];
            m_led = m_data;
        end
    end

    // Per-cycle compare of every output against the model.
    bit e_x, rw_x, rs_x, v_x, to_x, rdy_x;
    int ph, rd;
    always @(negedge clk) begin
        if (m_active) begin
            rd    = (m_t - 1) / PERIOD;
            ph    = (m_t - 1) % PERIOD + 1;
            e_x   = (ph >= 3) && (ph <= 14);
            rw_x  = (ph <= 15);
            rs_x  = m_rs;
            v_x   = (rd == m_n - 1) && (ph == 15);
            to_x  = v_x && m_to;
            rdy_x = 1'b0;
        end else begin
            e_x = 1'b0; rw_x = 1'b0; rs_x = 1'b0; v_x = 1'b0; to_x = 1'b0; rdy_x = 1'b1;
        end
        chk("lcd_e",       32'(bus.LCD_E),           32'(e_x));
        chk("lcd_rw",      32'(bus.LCD_RW),          32'(rw_x));
        chk("bus_release", 32'(bus.LCD_BUS_RELEASE), 32'(rw_x));
        chk("lcd_rs",      32'(bus.LCD_RS),          32'(rs_x));
        chk("rd_ready",    32'(bus.RD_READY),        32'(rdy_x));
        chk("rd_valid",    32'(bus.RD_VALID),        32'(v_x));
        chk("rd_timeout",  32'(bus.RD_TIMEOUT),      32'(to_x));
        chk("rd_data",     32'(bus.RD_DATA),         32'(m_data));
        chk("led",         32'(led),                 32'(m_led));
    end

    // Event monitor used by the hand-computed checks.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit prev_e      = 1'b0;
    int e_cyc       = -1;
    int valid_cyc   = -1;
    int to_cyc      = -1;
    int valid_cnt   = 0;
    int timeout_cnt = 0;
    always @(negedge clk) begin
        if (bus.LCD_E && !prev_e) e_cyc = cyc;
        prev_e = bus.LCD_E;
        if (bus.RD_VALID) begin
            valid_cnt++;
            valid_cyc = cyc;
        end
        if (bus.RD_TIMEOUT) begin
            timeout_cnt++;
            to_cyc = cyc;
        end
    end

    int acc_cyc, rdy_cyc, v_base, t_base;

    // Raise a request for one clock; acc_cyc is the first cycle after the accepting edge.
    task automatic start_read(input bit rs, input bit poll);
        @(negedge clk);
        resp_base   = e_rises;
        v_base      = valid_cnt;
        t_base      = timeout_cnt;
        bus.RD_RS   = rs;
        bus.RD_POLL = poll;
        bus.RD_REQ  = 1'b1;
        @(negedge clk);
        bus.RD_REQ  = 1'b0;
        acc_cyc     = cyc;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.RD_READY) begin
                rdy_cyc = cyc;
                return;
            end
        end
        rdy_cyc = -1;
        chk("ready_wait_expired", 32'(bus.RD_READY), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.RD_REQ  = 1'b0;
        bus.RD_RS   = 1'b0;
        bus.RD_POLL = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("init_led",   32'(led),          32'h00ff);
        chk("init_data",  32'(bus.RD_DATA),  32'h0000);
        chk("init_ready", 32'(bus.RD_READY), 32'd1);

        // Single status read.
        stim_resp = '{8'h25};
        start_read(1'b0, 1'b0);
        wait_ready();
        chk("t2_first_e_cycle", 32'(e_cyc - acc_cyc + 1),     32'd3);
        chk("t2_valid_cycle",   32'(valid_cyc - acc_cyc + 1), 32'd15);
        chk("t2_ready_cycle",   32'(rdy_cyc - acc_cyc + 1),   32'd29);
        chk("t2_data",          32'(bus.RD_DATA),             32'h25);
        chk("t2_e_pulses",      32'(e_rises - resp_base),     32'd1);
        chk("t2_valids",        32'(valid_cnt - v_base),      32'd1);

        // Data read.
        stim_resp = '{8'h41};
        start_read(1'b1, 1'b0);
        wait_ready();
        chk("t3_data",     32'(bus.RD_DATA),            32'h41);
        chk("t3_led",      32'(led),                    32'h41);
        chk("t3_timeouts", 32'(timeout_cnt - t_base),   32'd0);
        chk("t3_valids",   32'(valid_cnt - v_base),     32'd1);

        // Reset held in the middle of a read.
        stim_resp = '{8'h25};
        start_read(1'b0, 1'b0);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t1_e",       32'(bus.LCD_E),           32'd0);
        chk("t1_rw",      32'(bus.LCD_RW),          32'd0);
        chk("t1_rs",      32'(bus.LCD_RS),          32'd0);
        chk("t1_release", 32'(bus.LCD_BUS_RELEASE), 32'd0);
        chk("t1_valid",   32'(bus.RD_VALID),        32'd0);
        chk("t1_ready",   32'(bus.RD_READY),        32'd1);
        chk("t1_led",     32'(led),                 32'h00ff);
        chk("t1_data",    32'(bus.RD_DATA),         32'h0000);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("t1_no_valid", 32'(valid_cnt - v_base), 32'd0);

        // Busy poll that clears on the fourth read.
        stim_resp = '{8'h80, 8'h80, 8'h80, 8'h07};
        start_read(1'b0, 1'b1);
        wait_ready();
        chk("t4_e_pulses",    32'(e_rises - resp_base),   32'd4);
        chk("t4_valids",      32'(valid_cnt - v_base),    32'd1);
        chk("t4_timeouts",    32'(timeout_cnt - t_base),  32'd0);
        chk("t4_data",        32'(bus.RD_DATA),           32'h07);
        chk("t4_ready_cycle", 32'(rdy_cyc - acc_cyc + 1), 32'd113);

        // Busy poll that hits the attempt limit.
        stim_resp = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
        start_read(1'b0, 1'b1);
        wait_ready();
        chk("t5_e_pulses",    32'(e_rises - resp_base),     32'd4);
        chk("t5_valids",      32'(valid_cnt - v_base),      32'd1);
        chk("t5_timeouts",    32'(timeout_cnt - t_base),    32'd1);
        chk("t5_to_with_vld", 32'(to_cyc),                  32'(valid_cyc));
        chk("t5_valid_cycle", 32'(valid_cyc - acc_cyc + 1), 32'd99);
        chk("t5_data",        32'(bus.RD_DATA),             32'h80);
        chk("t5_ready",       32'(bus.RD_READY),            32'd1);

        // Request while busy is dropped; reset mid E pulse; then a clean read.
        stim_resp = '{8'h25};
        start_read(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        bus.RD_REQ = 1'b1;
        @(negedge clk);
        bus.RD_REQ = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_e_dropped", 32'(bus.LCD_E),  32'd0);
        chk("t6_rw_dropped", 32'(bus.LCD_RW), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("t6_e_pulses", 32'(e_rises - resp_base), 32'd1);
        chk("t6_no_valid", 32'(valid_cnt - v_base),  32'd0);
        stim_resp = '{8'h3c};
        start_read(1'b0, 1'b0);
        wait_ready();
        chk("t6_next_data",   32'(bus.RD_DATA),         32'h3c);
        chk("t6_next_valids", 32'(valid_cnt - v_base),  32'd1);
        chk("t6_next_pulses", 32'(e_rises - resp_base), 32'd1);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
